pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage 16-bit core. It generates every pipeline-register write-enable and bubble-insert signal from four inputs: load-use hazards in ID, branch/jump resolution from the execute stage's `flush`, instruction- and data-memory stalls, and HALT. It drains the pipeline on HALT and keeps saturating stall/flush counters for debug. It sits beside the datapath, beside the execute-stage forwarding unit.

---
 rtl/pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline write-enable / bubble controller with load-use, flush,
//            memory-stall and HALT-drain handling plus saturating debug counters.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      IFID_Instr,
    input  logic             IFID_ReadsRs,
    input  logic             IFID_ReadsRt,
    input  logic [15:0]      IDEX_Instr,
    input  logic             IDEX_MemRead,
    input  logic [2:0]       IDEX_DstRegNum,
    input  logic             flush,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             PC_WE,
    output logic             PC_Sel,
    output logic             IFID_WE,
    output logic             IDEX_WE,
    output logic             EXMEM_WE,
    output logic             MEMWB_WE,
    output logic             IFID_Bubble,
    output logic             IDEX_Bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int                DCNT_W       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCNT_W-1:0] c_DRAIN_LOAD = DCNT_W'(DRAIN_CYC - 1);
    localparam logic [DCNT_W-1:0] c_ONE        = DCNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DCNT_W-1:0]  r_drain_cnt;
    logic [DCNT_W-1:0]  w_drain_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               w_stall_inc;
    logic               w_flush_inc;
    logic               w_is_halt;
    logic               w_load_use;
    logic [2:0]         w_rs;
    logic [2:0]         w_rt;
    logic               w_unused_bits;

    assign w_rs       = IFID_Instr[10:8];
    assign w_rt       = IFID_Instr[7:5];
    assign w_is_halt  = (IDEX_Instr[15:11] == 5'b00000);
    assign w_load_use = IDEX_MemRead &&
                        ((IFID_ReadsRs && (w_rs == IDEX_DstRegNum)) ||
                         (IFID_ReadsRt && (w_rt == IDEX_DstRegNum)));
    assign w_unused_bits = ^{IFID_Instr[15:11], IFID_Instr[4:0], IDEX_Instr[10:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        PC_WE       = 1'b0;
        PC_Sel      = 1'b0;
        IFID_WE     = 1'b0;
        IDEX_WE     = 1'b0;
        EXMEM_WE    = 1'b0;
        MEMWB_WE    = 1'b0;
        IFID_Bubble = 1'b0;
        IDEX_Bubble = 1'b0;

        case (r_state)
            RUN: begin
                if (dmem_stall) begin
                    w_stall_inc = 1'b1;
                end else if (flush) begin
                    PC_WE       = 1'b1;
                    PC_Sel      = 1'b1;
                    IFID_WE     = 1'b1;
                    IDEX_WE     = 1'b1;
                    EXMEM_WE    = 1'b1;
                    MEMWB_WE    = 1'b1;
                    IFID_Bubble = 1'b1;
                    IDEX_Bubble = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (w_is_halt) begin
                    IFID_WE     = 1'b1;
                    IDEX_WE     = 1'b1;
                    EXMEM_WE    = 1'b1;
                    MEMWB_WE    = 1'b1;
                    IFID_Bubble = 1'b1;
                    IDEX_Bubble = 1'b1;
                    // A one-cycle drain retires HALT on this very edge.
                    if (DRAIN_CYC <= 1) begin
                        w_state_nxt = HALTED;
                        w_drain_nxt = '0;
                    end else begin
                        w_state_nxt = DRAIN;
                        w_drain_nxt = c_DRAIN_LOAD;
                    end
                end else if (w_load_use) begin
                    IDEX_WE     = 1'b1;
                    IDEX_Bubble = 1'b1;
                    EXMEM_WE    = 1'b1;
                    MEMWB_WE    = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (imem_stall) begin
                    IFID_WE     = 1'b1;
                    IFID_Bubble = 1'b1;
                    IDEX_WE     = 1'b1;
                    EXMEM_WE    = 1'b1;
                    MEMWB_WE    = 1'b1;
                    w_stall_inc = 1'b1;
                end else begin
                    PC_WE       = 1'b1;
                    IFID_WE     = 1'b1;
                    IDEX_WE     = 1'b1;
                    EXMEM_WE    = 1'b1;
                    MEMWB_WE    = 1'b1;
                end
            end

            DRAIN: begin
                IFID_WE     = 1'b1;
                IDEX_WE     = 1'b1;
                IFID_Bubble = 1'b1;
                IDEX_Bubble = 1'b1;
                EXMEM_WE    = !dmem_stall;
                MEMWB_WE    = !dmem_stall;
                // Leave when this non-stalled cycle takes the counter to zero,
                // so HALT retires exactly DRAIN_CYC unstalled cycles after EX.
                if (!dmem_stall) begin
                    if (r_drain_cnt <= c_ONE) begin
                        w_state_nxt = HALTED;
                        w_drain_nxt = '0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - c_ONE;
                    end
                end
            end

            HALTED: begin
                w_state_nxt = HALTED;
            end

            default: begin
                w_state_nxt = RUN;
                w_drain_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign halted    = (r_state == HALTED);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    a_halted_sticky : assert property (@(posedge clk) disable iff (!rst_n)
        halted |=> halted);

    a_halted_frozen : assert property (@(posedge clk) disable iff (!rst_n)
        halted |-> !(PC_WE || IFID_WE || IDEX_WE || EXMEM_WE || MEMWB_WE));

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed scoreboard bench for pipe_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] IFID_Instr = 16'h0800;
    logic        IFID_ReadsRs = 1'b0;
    logic        IFID_ReadsRt = 1'b0;
    logic [15:0] IDEX_Instr = 16'h0800;
    logic        IDEX_MemRead = 1'b0;
    logic [2:0]  IDEX_DstRegNum = 3'd0;
    logic        flush = 1'b0;
    logic        imem_stall = 1'b0;
    logic        dmem_stall = 1'b0;
    logic        PC_WE, PC_Sel, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE;
    logic        IFID_Bubble, IDEX_Bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(16), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_Instr(IFID_Instr), .IFID_ReadsRs(IFID_ReadsRs), .IFID_ReadsRt(IFID_ReadsRt),
        .IDEX_Instr(IDEX_Instr), .IDEX_MemRead(IDEX_MemRead), .IDEX_DstRegNum(IDEX_DstRegNum),
        .flush(flush), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .PC_WE(PC_WE), .PC_Sel(PC_Sel), .IFID_WE(IFID_WE), .IDEX_WE(IDEX_WE),
        .EXMEM_WE(EXMEM_WE), .MEMWB_WE(MEMWB_WE),
        .IFID_Bubble(IFID_Bubble), .IDEX_Bubble(IDEX_Bubble), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Control word: {PC_WE, PC_Sel, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE, IFID_Bubble, IDEX_Bubble, halted}
    localparam logic [8:0] c_NORMAL  = 9'b101111000;
    localparam logic [8:0] c_LOADUSE = 9'b000111010;
    localparam logic [8:0] c_FLUSH   = 9'b111111110;
    localparam logic [8:0] c_DSTALL  = 9'b000000000;
    localparam logic [8:0] c_IMSTALL = 9'b001111100;
    localparam logic [8:0] c_HALTGO  = 9'b001111110;
    localparam logic [8:0] c_DRAIN   = 9'b001111110;
    localparam logic [8:0] c_DRAINST = 9'b001100110;
    localparam logic [8:0] c_HALTED  = 9'b000000001;

    localparam logic [15:0] c_EX_OP  = 16'h0800;
    localparam logic [15:0] c_EX_HLT = 16'h0000;
    localparam logic [15:0] c_IF_RS3 = 16'h0B00;
    localparam logic [15:0] c_IF_RT3 = 16'h0860;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input string name, input logic rstv,
                        input logic [15:0] ifid, input logic rrs, input logic rrt,
                        input logic [15:0] idex, input logic mrd, input logic [2:0] dst,
                        input logic fl, input logic ims, input logic dms,
                        input logic [8:0] ctl, input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rstv;
        IFID_Instr     = ifid;
        IFID_ReadsRs   = rrs;
        IFID_ReadsRt   = rrt;
        IDEX_Instr     = idex;
        IDEX_MemRead   = mrd;
        IDEX_DstRegNum = dst;
        flush          = fl;
        imem_stall     = ims;
        dmem_stall     = dms;
        e.name = name;
        e.ctl  = ctl;
        e.sc   = sc;
        e.fc   = fc;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {PC_WE, PC_Sel, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE,
                       IFID_Bubble, IDEX_Bubble, halted};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
                end
                checks++;
                if (stall_cnt !== e.sc) begin
                    errors++;
                    $display("FAIL %s stall_cnt: got %h expected %h", e.name, stall_cnt, e.sc);
                end
                checks++;
                if (flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL %s flush_cnt: got %h expected %h", e.name, flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin : stim
        //        name         rst ifid      rs rt idex      mr dst  fl ims dms  ctl        sc       fc
        step("reset",          0, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_NORMAL,  16'd0, 16'd0);
        step("lu_rs",          1, c_IF_RS3, 1, 0, c_EX_OP,  1, 3'd3, 0, 0, 0, c_LOADUSE, 16'd0, 16'd0);
        step("lu_noread",      1, c_IF_RS3, 0, 0, c_EX_OP,  1, 3'd3, 0, 0, 0, c_NORMAL,  16'd1, 16'd0);
        step("lu_rt",          1, c_IF_RT3, 0, 1, c_EX_OP,  1, 3'd3, 0, 0, 0, c_LOADUSE, 16'd1, 16'd0);
        step("flush_over_lu",  1, c_IF_RS3, 1, 0, c_EX_OP,  1, 3'd3, 1, 0, 0, c_FLUSH,   16'd2, 16'd0);
        step("imem_stall",     1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 1, 0, c_IMSTALL, 16'd2, 16'd1);
        for (int i = 0; i < 4; i++)
            step("dmem_over_flush", 1, c_EX_OP, 0, 0, c_EX_OP, 0, 3'd0, 1, 0, 1, c_DSTALL, 16'(3 + i), 16'd1);
        step("after_dmem",     1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_NORMAL,  16'd7, 16'd1);
        step("halt_in_ex",     1, c_EX_OP,  0, 0, c_EX_HLT, 0, 3'd0, 0, 0, 0, c_HALTGO,  16'd7, 16'd1);
        step("drain_dstall",   1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 1, c_DRAINST, 16'd7, 16'd1);
        step("drain_ign_fl",   1, c_IF_RS3, 1, 0, c_EX_OP,  1, 3'd3, 1, 1, 0, c_DRAIN,   16'd7, 16'd1);
        step("drain_last",     1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_DRAIN,   16'd7, 16'd1);
        step("halted",         1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 1, 0, 0, c_HALTED,  16'd7, 16'd1);
        step("halted_hold",    1, c_IF_RS3, 1, 0, c_EX_OP,  1, 3'd3, 0, 1, 0, c_HALTED,  16'd7, 16'd1);
        step("halted_hold2",   1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_HALTED,  16'd7, 16'd1);
        step("reset_halted",   0, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_NORMAL,  16'd0, 16'd0);
        step("flush2",         1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 1, 0, 0, c_FLUSH,   16'd0, 16'd0);
        step("imem2",          1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 1, 0, c_IMSTALL, 16'd0, 16'd1);
        step("halt2",          1, c_EX_OP,  0, 0, c_EX_HLT, 0, 3'd0, 0, 0, 0, c_HALTGO,  16'd1, 16'd1);
        step("drain2",         1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_DRAIN,   16'd1, 16'd1);
        step("reset_drain",    0, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_NORMAL,  16'd0, 16'd0);
        step("run_after_rst",  1, c_IF_RS3, 1, 0, c_EX_OP,  1, 3'd3, 0, 0, 0, c_LOADUSE, 16'd0, 16'd0);
        step("run_after_rst2", 1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_NORMAL,  16'd1, 16'd0);

        @(posedge clk);
        #1;
        force dut.r_stall_cnt = 16'hFFFE;
        force dut.r_flush_cnt = 16'hFFFE;
        #1;
        release dut.r_stall_cnt;
        release dut.r_flush_cnt;

        step("sat_st0",        1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 1, 0, c_IMSTALL, 16'hFFFE, 16'hFFFE);
        step("sat_st1",        1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 1, 0, c_IMSTALL, 16'hFFFF, 16'hFFFE);
        step("sat_st2",        1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 1, 0, c_IMSTALL, 16'hFFFF, 16'hFFFE);
        step("sat_fl0",        1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 1, 0, 0, c_FLUSH,   16'hFFFF, 16'hFFFE);
        step("sat_fl1",        1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 1, 0, 0, c_FLUSH,   16'hFFFF, 16'hFFFF);
        step("sat_fl2",        1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 1, 0, 0, c_FLUSH,   16'hFFFF, 16'hFFFF);
        step("sat_final",      1, c_EX_OP,  0, 0, c_EX_OP,  0, 3'd0, 0, 0, 0, c_NORMAL,  16'hFFFF, 16'hFFFF);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
